gate_sweep_checker: RTL and testbench

Self-checking exhaustive stimulus engine for N-input combinational gates, and the synthesizable successor to our fixed 3-input gate sweeps. On start it drives every input pattern 0 to 2^N-1 to a gate under test and holds each pattern for a programmable settle time. It samples the gate output, compares it against a built-in reference function selected by MODE, and reports the error count, first failing vector and pass/done status. It sits beside any AND/OR-family gate instance, on-chip or in a bench harness.

---
 rtl/gate_sweep_checker.sv | 124 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every N-input pattern to a gate under test, holds each for HOLD_CYCLES,
// and checks the sampled output against a built-in AND/OR/XOR/NAND/NOR/XNOR reference.
module gate_sweep_checker #(
    parameter int N_INPUTS    = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int MODE        = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dut_o,
    output logic [N_INPUTS-1:0] vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                first_fail_valid
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

    if (MODE < 0 || MODE > 5) begin : g_bad_mode
        $error("gate_sweep_checker: MODE must be 0..5");
    end
    if (N_INPUTS < 2 || N_INPUTS > 16 || HOLD_CYCLES < 1) begin : g_bad_size
        $error("gate_sweep_checker: N_INPUTS must be 2..16 and HOLD_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] vec_q, vec_d, ffv_q, ffv_d;
    logic [N_INPUTS:0]   err_q, err_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffvalid_q, ffvalid_d;
    logic                expected, mism;

    assign expected = (MODE == 0) ? &vec_q :
                      (MODE == 1) ? |vec_q :
                      (MODE == 2) ? ^vec_q :
                      (MODE == 3) ? ~&vec_q :
                      (MODE == 4) ? ~|vec_q : ~^vec_q;
    assign mism = dut_o != expected;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        case (state_q)
            RUN: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HLAST) begin
                    err_d = err_q + (N_INPUTS+1)'(mism);
                    if (mism && !ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                    // terminal compare precedes the increment so vec never wraps
                    if (&vec_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = err_d == '0;
                    end else begin
                        vec_d  = vec_q + 1'b1;
                        hold_d = '0;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d   = RUN;
                    vec_d     = '0;
                    hold_d    = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            hold_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed scenarios over four checker configurations (AND3, OR3, XOR4 H=1, NAND3)
// with a selectable gate model (ideal, tied 0, tied 1, inverted, AND-instead-of-reference).
module tb_gate_sweep_checker;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    int sel = 0, mdl = 0, errors = 0, checks = 0, cyc = 0, maxerr = 0;
    logic busy0, done0;
    logic [3:0] trace [0:63];

    always #5 clk = ~clk;

    logic [2:0] va, vb, vd, fa, fb, fd;
    logic [3:0] vc, fc, ea, eb, ed;
    logic [4:0] ec;
    logic ba, bb, bc, bd, da, db, dc, dd, pa, pb, pc, pd, qa, qb, qc, qd, oa, ob, oc, od;

    function automatic logic drv(input int m, input logic ideal, input logic andv);
        return (m == 0) ? ideal : (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (m == 3) ? ~ideal : andv;
    endfunction

    assign oa = drv(mdl, &va, &va);
    assign ob = drv(mdl, |vb, &vb);
    assign oc = drv(mdl, ^vc, &vc);
    assign od = drv(mdl, ~&vd, &vd);

    gate_sweep_checker #(.N_INPUTS(3), .HOLD_CYCLES(4), .MODE(0)) u_and (.clk(clk), .rst_n(rst_n),
        .start(start && sel == 0), .dut_o(oa), .vec(va), .busy(ba), .done(da), .pass(pa),
        .err_count(ea), .first_fail_vec(fa), .first_fail_valid(qa));
    gate_sweep_checker #(.N_INPUTS(3), .HOLD_CYCLES(4), .MODE(1)) u_or (.clk(clk), .rst_n(rst_n),
        .start(start && sel == 1), .dut_o(ob), .vec(vb), .busy(bb), .done(db), .pass(pb),
        .err_count(eb), .first_fail_vec(fb), .first_fail_valid(qb));
    gate_sweep_checker #(.N_INPUTS(4), .HOLD_CYCLES(1), .MODE(2)) u_xor (.clk(clk), .rst_n(rst_n),
        .start(start && sel == 2), .dut_o(oc), .vec(vc), .busy(bc), .done(dc), .pass(pc),
        .err_count(ec), .first_fail_vec(fc), .first_fail_valid(qc));
    gate_sweep_checker #(.N_INPUTS(3), .HOLD_CYCLES(4), .MODE(3)) u_nand (.clk(clk), .rst_n(rst_n),
        .start(start && sel == 3), .dut_o(od), .vec(vd), .busy(bd), .done(dd), .pass(pd),
        .err_count(ed), .first_fail_vec(fd), .first_fail_valid(qd));

    logic [3:0] o_vec, o_ffv;
    logic [4:0] o_err;
    logic o_busy, o_done, o_pass, o_ffvalid;

    always_comb begin
        o_vec     = (sel == 0) ? {1'b0, va} : (sel == 1) ? {1'b0, vb} : (sel == 2) ? vc : {1'b0, vd};
        o_ffv     = (sel == 0) ? {1'b0, fa} : (sel == 1) ? {1'b0, fb} : (sel == 2) ? fc : {1'b0, fd};
        o_err     = (sel == 0) ? {1'b0, ea} : (sel == 1) ? {1'b0, eb} : (sel == 2) ? ec : {1'b0, ed};
        o_busy    = (sel == 0) ? ba : (sel == 1) ? bb : (sel == 2) ? bc : bd;
        o_done    = (sel == 0) ? da : (sel == 1) ? db : (sel == 2) ? dc : dd;
        o_pass    = (sel == 0) ? pa : (sel == 1) ? pb : (sel == 2) ? pc : pd;
        o_ffvalid = (sel == 0) ? qa : (sel == 1) ? qb : (sel == 2) ? qc : qd;
    end

    // Pulses start and waits (bounded) for done; cyc counts clock edges after the accepting edge.
    task automatic do_sweep;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        busy0 = o_busy; done0 = o_done; cyc = 0; maxerr = 0;
        while (!o_done && cyc < 200) begin
            if (cyc < 64) trace[cyc] = o_vec;
            if (int'(o_err) > maxerr) maxerr = int'(o_err);
            @(posedge clk); #1; cyc++;
        end
        if (int'(o_err) > maxerr) maxerr = int'(o_err);
    endtask

    task automatic test_reset;
        sel = 0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_vec !== 4'd0) begin errors++; $display("FAIL reset_vec got=%0d exp=0", o_vec); end
        checks++; if ({o_busy, o_done, o_pass, o_ffvalid} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {o_busy, o_done, o_pass, o_ffvalid}); end
        checks++; if (o_err !== 5'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", o_err); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_and_ideal;
        sel = 0; mdl = 0;
        do_sweep();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL and_busy_at_start got=%b exp=1", busy0); end
        checks++; if (cyc !== 32) begin errors++; $display("FAIL and_latency got=%0d exp=32", cyc); end
        checks++; if (trace[0] !== 4'd0 || trace[3] !== 4'd0 || trace[4] !== 4'd1) begin errors++; $display("FAIL and_vec_hold got=%0d,%0d,%0d exp=0,0,1", trace[0], trace[3], trace[4]); end
        checks++; if (trace[27] !== 4'd6 || trace[28] !== 4'd7 || trace[31] !== 4'd7) begin errors++; $display("FAIL and_vec_tail got=%0d,%0d,%0d exp=6,7,7", trace[27], trace[28], trace[31]); end
        checks++; if (o_err !== 5'd0 || o_pass !== 1'b1 || o_ffvalid !== 1'b0) begin errors++; $display("FAIL and_result got err=%0d pass=%b ffvalid=%b exp err=0 pass=1 ffvalid=0", o_err, o_pass, o_ffvalid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL and_busy_done got=%b exp=0", o_busy); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_done !== 1'b1 || o_vec !== 4'd7 || o_pass !== 1'b1) begin errors++; $display("FAIL and_done_hold got done=%b vec=%0d pass=%b exp 1,7,1", o_done, o_vec, o_pass); end
    endtask

    task automatic test_and_tied0;
        sel = 0; mdl = 1;
        do_sweep();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL tied0_done_drop got=%b exp=0", done0); end
        checks++; if (o_err !== 5'd1 || o_ffv !== 4'd7 || o_ffvalid !== 1'b1 || o_pass !== 1'b0) begin errors++; $display("FAIL tied0_result got err=%0d ffv=%0d ffvalid=%b pass=%b exp 1,7,1,0", o_err, o_ffv, o_ffvalid, o_pass); end
    endtask

    task automatic test_or;
        sel = 1; mdl = 2;
        do_sweep();
        checks++; if (o_err !== 5'd1 || o_ffv !== 4'd0 || o_ffvalid !== 1'b1 || o_pass !== 1'b0) begin errors++; $display("FAIL or_tied1 got err=%0d ffv=%0d ffvalid=%b pass=%b exp 1,0,1,0", o_err, o_ffv, o_ffvalid, o_pass); end
        mdl = 3;
        do_sweep();
        checks++; if (o_err !== 5'd8 || o_ffv !== 4'd0 || o_ffvalid !== 1'b1) begin errors++; $display("FAIL or_inverted got err=%0d ffv=%0d ffvalid=%b exp 8,0,1", o_err, o_ffv, o_ffvalid); end
    endtask

    task automatic test_back_to_back;
        sel = 2; mdl = 0;
        do_sweep();
        checks++; if (cyc !== 16 || o_pass !== 1'b1 || o_err !== 5'd0) begin errors++; $display("FAIL xor_first got cyc=%0d pass=%b err=%0d exp 16,1,0", cyc, o_pass, o_err); end
        checks++; if (trace[0] !== 4'd0 || trace[1] !== 4'd1 || trace[15] !== 4'd15) begin errors++; $display("FAIL xor_vec_step got=%0d,%0d,%0d exp=0,1,15", trace[0], trace[1], trace[15]); end
        do_sweep();
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL xor_restart got done=%b busy=%b exp 0,1", done0, busy0); end
        checks++; if (cyc !== 16 || o_pass !== 1'b1 || o_err !== 5'd0 || o_vec !== 4'd15) begin errors++; $display("FAIL xor_second got cyc=%0d pass=%b err=%0d vec=%0d exp 16,1,0,15", cyc, o_pass, o_err, o_vec); end
    endtask

    task automatic test_start_ignored_and_reset;
        sel = 0; mdl = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc = 0;
        while (o_vec !== 4'd2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc++;
        checks++; if (o_vec !== 4'd2 || o_busy !== 1'b1) begin errors++; $display("FAIL ignore_start got vec=%0d busy=%b exp 2,1", o_vec, o_busy); end
        while (!o_done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 32 || o_pass !== 1'b1) begin errors++; $display("FAIL ignore_sweep got cyc=%0d pass=%b exp 32,1", cyc, o_pass); end
        mdl = 3;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc = 0;
        while (o_vec !== 4'd5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (o_err !== 5'd5 || o_ffvalid !== 1'b1) begin errors++; $display("FAIL pre_reset got err=%0d ffvalid=%b exp 5,1", o_err, o_ffvalid); end
        #3; rst_n = 1'b0;
        #1;
        checks++; if (o_vec !== 4'd0 || o_err !== 5'd0 || {o_busy, o_done, o_pass, o_ffvalid} !== 4'b0 || o_ffv !== 4'd0) begin errors++; $display("FAIL async_reset got vec=%0d err=%0d flags=%b ffv=%0d exp all 0", o_vec, o_err, {o_busy, o_done, o_pass, o_ffvalid}, o_ffv); end
        #1; rst_n = 1'b1; mdl = 0;
        do_sweep();
        checks++; if (cyc !== 32 || o_pass !== 1'b1 || o_err !== 5'd0) begin errors++; $display("FAIL post_reset got cyc=%0d pass=%b err=%0d exp 32,1,0", cyc, o_pass, o_err); end
    endtask

    task automatic test_nand_wrong;
        sel = 3; mdl = 4;
        do_sweep();
        checks++; if (o_err !== 5'd8 || o_pass !== 1'b0 || o_ffv !== 4'd0 || o_ffvalid !== 1'b1) begin errors++; $display("FAIL nand_result got err=%0d pass=%b ffv=%0d ffvalid=%b exp 8,0,0,1", o_err, o_pass, o_ffv, o_ffvalid); end
        checks++; if (maxerr > 8) begin errors++; $display("FAIL nand_max_err got=%0d exp<=8", maxerr); end
        checks++; if (cyc !== 32) begin errors++; $display("FAIL nand_latency got=%0d exp=32", cyc); end
    endtask

    initial begin
        test_reset();
        test_and_ideal();
        test_and_tied0();
        test_or();
        test_back_to_back();
        test_start_ignored_and_reset();
        test_nand_wrong();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
